// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the multiply/divide occupancy FSM states.
package pipe_pkg;

  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_EXALU  = 2'd1;
  localparam logic [1:0] FWD_MEMALU = 2'd2;
  localparam logic [1:0] FWD_MEMLD  = 2'd3;

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): ID/EX/MEM stage status in, stage control and counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md;
  logic             id_hilo;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [4:0]       ex_rn;
  logic             mem_wreg;
  logic             mem_m2reg;
  logic [4:0]       mem_rn;
  logic             ex_br_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             md_start;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_hilo,
    output ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn, ex_br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, md_start,
    input  fwda, fwdb, md_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_hilo,
    input  ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn, ex_br_taken,
    output pc_en, ifid_en, ifid_flush, idex_bubble, md_start,
    output fwda, fwdb, md_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one ID-stage source register.
// A load in EX cannot forward (its data is not ready); that case is a stall.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] id_r,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwd
);

  logic ex_hit;
  logic mem_hit;

  // Youngest producer wins: EX result beats the MEM result
  always_comb begin
    ex_hit  = ex_wreg & ~ex_m2reg & (ex_rn != 5'd0) & (ex_rn == id_r);
    mem_hit = mem_wreg & (mem_rn != 5'd0) & (mem_rn == id_r);
    if (ex_hit) begin
      fwd = FWD_EXALU;
    end else if (mem_hit && mem_m2reg) begin
      fwd = FWD_MEMLD;
    end else if (mem_hit) begin
      fwd = FWD_MEMALU;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use and MD-unit
// stalls, branch flush, MD occupancy tracking and saturating event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               clrn,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int               MDC_W   = 6;
  localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  md_state_t        state;
  md_state_t        state_nx;
  logic [MDC_W-1:0] md_cnt;
  logic [MDC_W-1:0] md_cnt_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             load_use;
  logic             md_haz;
  logic             stall;
  logic             md_busy;
  logic             md_start;

  fwd_sel u_fwda (
    .id_r      (bus.id_rs),
    .ex_wreg   (bus.ex_wreg),
    .ex_m2reg  (bus.ex_m2reg),
    .ex_rn     (bus.ex_rn),
    .mem_wreg  (bus.mem_wreg),
    .mem_m2reg (bus.mem_m2reg),
    .mem_rn    (bus.mem_rn),
    .fwd       (bus.fwda)
  );

  fwd_sel u_fwdb (
    .id_r      (bus.id_rt),
    .ex_wreg   (bus.ex_wreg),
    .ex_m2reg  (bus.ex_m2reg),
    .ex_rn     (bus.ex_rn),
    .mem_wreg  (bus.mem_wreg),
    .mem_m2reg (bus.mem_m2reg),
    .mem_rn    (bus.mem_rn),
    .fwd       (bus.fwdb)
  );

  // Hazard detection; md_busy is decoded from state so reset clears it at once
  always_comb begin
    load_use = bus.ex_wreg & bus.ex_m2reg & (bus.ex_rn != 5'd0) &
               ((bus.id_use_rs & (bus.ex_rn == bus.id_rs)) |
                (bus.id_use_rt & (bus.ex_rn == bus.id_rt)));
    md_busy  = (state == MDWAIT);
    md_haz   = md_busy & (bus.id_md | bus.id_hilo);
    stall    = (load_use | md_haz) & ~bus.ex_br_taken;
    md_start = bus.id_md & ~stall & ~bus.ex_br_taken;
  end

  // Stage enables: a taken branch squashes IF/ID and ID/EX and overrides stall
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (bus.ex_br_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (stall) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.idex_bubble = 1'b1;
    end else begin
      bus.pc_en       = 1'b1;
      bus.ifid_en     = 1'b1;
    end
  end

  // MD occupancy next state; counter value 0 marks the last busy cycle
  always_comb begin
    state_nx  = state;
    md_cnt_nx = md_cnt;
    case (state)
      RUN: begin
        if (md_start) begin
          state_nx  = MDWAIT;
          md_cnt_nx = MD_LOAD;
        end else begin
          state_nx  = RUN;
        end
      end
      MDWAIT: begin
        if (md_cnt == {MDC_W{1'b0}}) begin
          state_nx  = RUN;
        end else begin
          md_cnt_nx = md_cnt - MDC_W'(1);
        end
      end
      default: begin
        state_nx  = RUN;
        md_cnt_nx = {MDC_W{1'b0}};
      end
    endcase
  end

  // MD state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= RUN;
      md_cnt <= {MDC_W{1'b0}};
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bus.ex_br_taken && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.md_busy   = md_busy;
  assign bus.md_start  = md_start;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// hand-written multi-cycle MD, flush, reset and saturation sequences.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic clrn;
  int   errors;
  int   checks;

  pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       md;
    logic       hilo;
    logic       exw;
    logic       exm;
    logic [4:0] exrn;
    logic       mw;
    logic       mm;
    logic [4:0] mrn;
    logic       br;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pc;
    logic       ifid;
    logic       fl;
    logic       bub;
    logic       ms;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_md = 1'b0; bus.id_hilo = 1'b0; bus.ex_wreg = 1'b0; bus.ex_m2reg = 1'b0;
    bus.ex_rn = 5'd0; bus.mem_wreg = 1'b0; bus.mem_m2reg = 1'b0; bus.mem_rn = 5'd0;
    bus.ex_br_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    clr_in();
    #1;
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic set_load_use();
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = 5'd5;
    bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int stall_seen;
    int start_idx;
    errors = 0;
    checks = 0;

    //        rs     rt    urs   urt   md    hilo  exw   exm   exrn   mw    mm    mrn    br    fa    fb    pc    ifid  fl    bub   ms
    vt[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{5'd0, 5'd12,1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12,1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{5'd0, 5'd12,1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12,1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[12] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[15] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, before and across a clock edge
    clrn = 1'b0;
    clr_in();
    #2;
    chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst_ifid_en", 32'(bus.ifid_en), 32'd1);
    chk("rst_flush", 32'(bus.ifid_flush), 32'd0);
    chk("rst_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("rst_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_md_start", 32'(bus.md_start), 32'd0);
    chk("rst_fwd", 32'({bus.fwda, bus.fwdb}), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    // Combinational vector table
    for (int i = 0; i < 16; i++) begin
      step();
      bus.id_rs = vt[i].rs; bus.id_rt = vt[i].rt;
      bus.id_use_rs = vt[i].use_rs; bus.id_use_rt = vt[i].use_rt;
      bus.id_md = vt[i].md; bus.id_hilo = vt[i].hilo;
      bus.ex_wreg = vt[i].exw; bus.ex_m2reg = vt[i].exm; bus.ex_rn = vt[i].exrn;
      bus.mem_wreg = vt[i].mw; bus.mem_m2reg = vt[i].mm; bus.mem_rn = vt[i].mrn;
      bus.ex_br_taken = vt[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d_fwda", i), 32'(bus.fwda), 32'(vt[i].fa));
      chk($sformatf("vec%0d_fwdb", i), 32'(bus.fwdb), 32'(vt[i].fb));
      chk($sformatf("vec%0d_pc_en", i), 32'(bus.pc_en), 32'(vt[i].pc));
      chk($sformatf("vec%0d_ifid_en", i), 32'(bus.ifid_en), 32'(vt[i].ifid));
      chk($sformatf("vec%0d_flush", i), 32'(bus.ifid_flush), 32'(vt[i].fl));
      chk($sformatf("vec%0d_bubble", i), 32'(bus.idex_bubble), 32'(vt[i].bub));
      chk($sformatf("vec%0d_md_start", i), 32'(bus.md_start), 32'(vt[i].ms));
    end

    // Load-use: one stall cycle, counter 0 -> 1
    do_reset();
    step();
    set_load_use();
    @(negedge clk);
    chk("lu_pc_en", 32'(bus.pc_en), 32'd0);
    chk("lu_stall_cnt_before", 32'(bus.stall_cnt), 32'd0);
    step();
    clr_in();
    @(negedge clk);
    chk("lu_stall_cnt_after", 32'(bus.stall_cnt), 32'd1);
    chk("lu_pc_en_after", 32'(bus.pc_en), 32'd1);

    // Flush beats stall: flush_cnt +1, stall_cnt unchanged
    step();
    set_load_use();
    bus.ex_br_taken = 1'b1;
    @(negedge clk);
    chk("fb_flush", 32'(bus.ifid_flush), 32'd1);
    chk("fb_pc_en", 32'(bus.pc_en), 32'd1);
    chk("fb_ifid_en", 32'(bus.ifid_en), 32'd1);
    step();
    clr_in();
    @(negedge clk);
    chk("fb_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("fb_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // MD timing: one id_md pulse, then id_hilo held across the busy window
    do_reset();
    step();
    bus.id_md = 1'b1;
    @(negedge clk);
    chk("md_start_pulse", 32'(bus.md_start), 32'd1);
    chk("md_busy_pre", 32'(bus.md_busy), 32'd0);
    step();
    bus.id_md = 1'b0;
    bus.id_hilo = 1'b1;
    busy_cnt = 0;
    stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.md_busy) break;
      busy_cnt++;
      if (!bus.pc_en) stall_seen++;
      step();
    end
    chk("md_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("md_stall_cycles", 32'(stall_seen), 32'd4);
    chk("md_stall_cnt", 32'(bus.stall_cnt), 32'd4);
    chk("md_hilo_released", 32'(bus.pc_en), 32'd1);
    step();
    clr_in();

    // Back-to-back MD: second start right after busy falls, then async reset
    do_reset();
    step();
    bus.id_md = 1'b1;
    @(negedge clk);
    chk("b2b_start1", 32'(bus.md_start), 32'd1);
    start_idx = -1;
    busy_cnt = 0;
    for (int c = 1; c < 12; c++) begin
      step();
      @(negedge clk);
      if (bus.md_start) begin
        start_idx = c;
        break;
      end
      if (bus.md_busy) busy_cnt++;
    end
    chk("b2b_start2_cycle", 32'(start_idx), 32'd5);
    chk("b2b_busy_cycles", 32'(busy_cnt), 32'd4);
    step();
    bus.id_md = 1'b0;
    chk("b2b_busy_again", 32'(bus.md_busy), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("b2b_async_busy", 32'(bus.md_busy), 32'd0);
    chk("b2b_async_pc_en", 32'(bus.pc_en), 32'd1);
    @(negedge clk);
    clrn = 1'b1;

    // Saturation: 20 stall cycles on a 4-bit counter
    do_reset();
    step();
    set_load_use();
    repeat (19) @(posedge clk);
    step();
    clr_in();
    @(negedge clk);
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
    step();
    @(negedge clk);
    chk("sat_stall_cnt_hold", 32'(bus.stall_cnt), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 32: cycles a multiply/divide occupies the MD unit, legal range 2..63.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 each: source register numbers of the ID-stage instruction.
REQ-006 SHALL have ports id_use_rs, id_use_rt, input, 1 each: the ID-stage instruction reads that source.
REQ-007 SHALL have ports id_md (ID instruction is mult/div) and id_hilo (ID instruction reads HI/LO), input, 1 each.
REQ-008 SHALL have ports ex_wreg, ex_m2reg (input, 1) and ex_rn (input, 5): EX-stage write-enable, load flag and destination.
REQ-009 SHALL have ports mem_wreg, mem_m2reg (input, 1) and mem_rn (input, 5): the same signals for the MEM stage.
REQ-010 SHALL have port ex_br_taken, input, 1: the branch/jump resolved in EX is taken.
REQ-011 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_bubble and md_start, 1 each: PC write, IF/ID enable, IF/ID flush, ID/EX zero-insert, MD launch pulse.
REQ-012 SHALL have outputs fwda and fwdb, 2 each: operand source selects (0 regfile, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data).
REQ-013 SHALL have outputs md_busy (1), stall_cnt and flush_cnt (CNT_W each).

Function
REQ-014 fwda SHALL be combinational: 1 if ex_wreg, !ex_m2reg, ex_rn!=0 and ex_rn==id_rs; else 3 if mem_wreg, mem_m2reg, mem_rn!=0 and mem_rn==id_rs; else 2 if mem_wreg, mem_rn!=0 and mem_rn==id_rs; else 0.
REQ-015 fwdb SHALL follow REQ-014 with id_rt substituted; the EX match always beats the MEM match.
REQ-016 A load-use hazard SHALL be ex_wreg & ex_m2reg & ex_rn!=0 & ((id_use_rs & ex_rn==id_rs) | (id_use_rt & ex_rn==id_rt)).
REQ-017 An MD hazard SHALL be md_busy & (id_md | id_hilo).
REQ-018 stall SHALL equal (load-use | MD hazard) & !ex_br_taken; while it holds, pc_en=0, ifid_en=0 and idex_bubble=1, all combinational in the same cycle.
REQ-019 When ex_br_taken=1: ifid_flush=1, idex_bubble=1 and pc_en=1, regardless of any hazard; flush beats stall.
REQ-020 With no stall and no flush: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
REQ-021 FSM states: RUN and MDWAIT. md_busy SHALL be 1 exactly in MDWAIT.
REQ-022 md_start SHALL be 1 for one cycle when id_md=1, stall=0 and ex_br_taken=0.
REQ-023 On md_start the FSM SHALL go to MDWAIT and load the down-counter with MD_LAT-1; in MDWAIT the counter SHALL decrement each cycle.
REQ-024 The FSM SHALL return to RUN on the edge at which the counter reads 0, so md_busy lasts exactly MD_LAT cycles.
REQ-025 An id_md stalled by MD hazard SHALL issue md_start in the first RUN cycle, with no idle gap.
REQ-026 ex_br_taken SHALL NOT abort an MD operation already in MDWAIT.
REQ-027 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt on each cycle with ex_br_taken=1; both saturate at all-ones and never wrap.

Reset
REQ-028 clrn=0 SHALL asynchronously force state RUN, MD counter 0, stall_cnt 0 and flush_cnt 0.
REQ-029 During and after reset, with all inputs 0, outputs SHALL be pc_en=1, ifid_en=1, all others 0.
REQ-030 Reset in MDWAIT SHALL drop md_busy immediately, without waiting for a clock edge.

Structure
REQ-031 Package pipe_pkg SHALL hold the FWD_RF/FWD_EXALU/FWD_MEMALU/FWD_MEMLD codes (0..3) and the FSM state encodings.
REQ-032 Sub-module fwd_sel SHALL implement REQ-014 for one operand and be instantiated twice, once for id_rs and once for id_rt.

Verification
REQ-033 Load-use: ex_wreg=1, ex_m2reg=1, ex_rn=5, id_rs=5, id_use_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, stall_cnt 0->1.
REQ-034 Forwarding priority: ex_rn=mem_rn=7, both wreg, mem_m2reg=1, id_rt=7 -> fwdb=1; drop ex_wreg -> fwdb=3; rn=0 -> fwdb=0.
REQ-035 MD timing: MD_LAT=4, id_md pulse -> md_start one cycle, md_busy exactly 4 cycles; id_hilo held -> stalled 4 cycles, stall_cnt=4.
REQ-036 Flush beats stall: load-use hazard plus ex_br_taken=1 -> ifid_flush=1, pc_en=1, ifid_en held, flush_cnt+1, stall_cnt unchanged.
REQ-037 Back-to-back MD: two id_md, MD_LAT=4 -> second md_start in the cycle after md_busy falls; clrn pulse mid-MDWAIT -> md_busy=0 at once.
REQ-038 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15 held.
